// File: rtl/demux_lane_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_lane_scheduler_pkg
// Brief    : Shared state encodings, lane indices and default widths.
// Revision : 1.0
// ============================================================================
package demux_lane_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_STALL  = 2'b10
  } state_e;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_CNT_W  = 8;

endpackage
`default_nettype wire

// File: rtl/demux_lane_scheduler_lane_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : lane_out_reg
// Brief    : Per-lane registered output word with valid and load enable.
// Revision : 1.0
// ============================================================================
module lane_out_reg
  import demux_lane_scheduler_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // Data holds its last value when the lane is not loaded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= load_i;
      if (load_i) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/demux_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : demux_lane_scheduler
// Brief    : Round-robin 1-to-2 demux with almost-full skip and back-pressure.
// Revision : 1.0
// ============================================================================
module demux_lane_scheduler
  import demux_lane_scheduler_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int IDLE_TO = 4
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              almost_full0,
  input  logic              almost_full1,
  output logic              ready_out,
  output logic              validout0,
  output logic              validout1,
  output logic [DATA_W-1:0] dataout0,
  output logic [DATA_W-1:0] dataout1,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [1:0]        state
);

  localparam int ICW = (IDLE_TO < 2) ? 1 : $clog2(IDLE_TO + 1);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [ICW-1:0]   idle_q, idle_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic       w_accept;
  logic       w_ptr_eff;
  logic       w_lane;
  logic [1:0] w_af;

  assign w_af      = {almost_full1, almost_full0};
  assign ready_out = ~(almost_full0 & almost_full1);
  assign w_accept  = valid_in & ready_out;
  // IDLE always steers from lane 0 regardless of the stored pointer.
  assign w_ptr_eff = (state_q == ST_IDLE) ? LANE0 : ptr_q;
  assign w_lane    = w_af[w_ptr_eff] ? ~w_ptr_eff : w_ptr_eff;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idle_d  = idle_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;

    case (state_q)
      ST_IDLE: begin
        idle_d = '0;
        ptr_d  = LANE0;
        if (w_accept) begin
          state_d = ST_ACTIVE;
        end else if (valid_in) begin
          state_d = ST_STALL;
        end
      end
      ST_ACTIVE: begin
        if (valid_in) begin
          idle_d = '0;
          if (!ready_out) begin
            state_d = ST_STALL;
          end
        end else if (idle_q == ICW'(IDLE_TO - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = LANE0;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + ICW'(1);
        end
      end
      ST_STALL: begin
        idle_d = '0;
        if (ready_out) begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = LANE0;
        idle_d  = '0;
      end
    endcase

    if (w_accept) begin
      ptr_d = ~w_lane;
      if (w_lane == LANE0) begin
        cnt0_d = cnt0_q + CNT_W'(1);
      end else begin
        cnt1_d = cnt1_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= LANE0;
      idle_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idle_q  <= idle_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  lane_out_reg #(.DATA_W(DATA_W)) u_lane0 (
    .clk_i   (clk_4f),
    .rst_i   (reset),
    .load_i  (w_accept & (w_lane == LANE0)),
    .data_i  (data_in),
    .valid_o (validout0),
    .data_o  (dataout0)
  );

  lane_out_reg #(.DATA_W(DATA_W)) u_lane1 (
    .clk_i   (clk_4f),
    .rst_i   (reset),
    .load_i  (w_accept & (w_lane == LANE1)),
    .data_i  (data_in),
    .valid_o (validout1),
    .data_o  (dataout1)
  );

  assign cnt0  = cnt0_q;
  assign cnt1  = cnt1_q;
  assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_lane_scheduler
// Brief    : Directed vector table plus counter-wrap sequence for the demux.
// Revision : 1.0
// ============================================================================
module tb_demux_lane_scheduler;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [7:0] data_in;
  logic       almost_full0;
  logic       almost_full1;
  logic       ready_out;
  logic       validout0, validout1;
  logic [7:0] dataout0, dataout1;
  logic [7:0] cnt0, cnt1;
  logic [1:0] state;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_4f = ~clk_4f;

  demux_lane_scheduler #(.DATA_W(8), .CNT_W(8), .IDLE_TO(4)) dut (
    .clk_4f       (clk_4f),
    .reset        (reset),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .almost_full0 (almost_full0),
    .almost_full1 (almost_full1),
    .ready_out    (ready_out),
    .validout0    (validout0),
    .validout1    (validout1),
    .dataout0     (dataout0),
    .dataout1     (dataout1),
    .cnt0         (cnt0),
    .cnt1         (cnt1),
    .state        (state)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] din;
    logic       af0;
    logic       af1;
    logic       rdy;
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] st;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  function automatic vec_t mk(logic rst, logic vld, logic [7:0] din, logic af0, logic af1,
                              logic rdy, logic v0, logic v1, logic [7:0] d0, logic [7:0] d1,
                              logic [7:0] c0, logic [7:0] c1, logic [1:0] st);
    vec_t v;
    v.rst = rst; v.vld = vld; v.din = din; v.af0 = af0; v.af1 = af1; v.rdy = rdy;
    v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1; v.c0 = c0; v.c1 = c1; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  initial begin
    int spurious;
    //                rst vld din    af0 af1 rdy v0 v1 d0     d1     c0     c1     st
    // Reset asserted while a word is presented
    tbl[0]  = mk(1, 1, 8'h5A, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'd0, 8'd0, 2'b00);
    tbl[1]  = mk(1, 1, 8'h5A, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'd0, 8'd0, 2'b00);
    // Round robin
    tbl[2]  = mk(0, 1, 8'h11, 0, 0, 1, 1, 0, 8'h11, 8'h00, 8'd1, 8'd0, 2'b01);
    tbl[3]  = mk(0, 1, 8'h22, 0, 0, 1, 0, 1, 8'h11, 8'h22, 8'd1, 8'd1, 2'b01);
    tbl[4]  = mk(0, 1, 8'h33, 0, 0, 1, 1, 0, 8'h33, 8'h22, 8'd2, 8'd1, 2'b01);
    tbl[5]  = mk(0, 1, 8'h44, 0, 0, 1, 0, 1, 8'h33, 8'h44, 8'd2, 8'd2, 2'b01);
    // Reset mid-stream drops everything
    tbl[6]  = mk(1, 1, 8'h5A, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'd0, 8'd0, 2'b00);
    tbl[7]  = mk(1, 1, 8'h5A, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'd0, 8'd0, 2'b00);
    // Skip lane 0 while almost full
    tbl[8]  = mk(0, 1, 8'hA1, 1, 0, 1, 0, 1, 8'h00, 8'hA1, 8'd0, 8'd1, 2'b01);
    tbl[9]  = mk(0, 1, 8'hA2, 1, 0, 1, 0, 1, 8'h00, 8'hA2, 8'd0, 8'd2, 2'b01);
    // Both full: stall, then release lane 1
    tbl[10] = mk(0, 1, 8'hC3, 1, 1, 0, 0, 0, 8'h00, 8'hA2, 8'd0, 8'd2, 2'b10);
    tbl[11] = mk(0, 1, 8'hC3, 1, 1, 0, 0, 0, 8'h00, 8'hA2, 8'd0, 8'd2, 2'b10);
    tbl[12] = mk(0, 1, 8'hC3, 1, 0, 1, 0, 1, 8'h00, 8'hC3, 8'd0, 8'd3, 2'b01);
    // Idle realign: word to lane 0, four idle cycles, next word back on lane 0
    tbl[13] = mk(0, 1, 8'h55, 0, 0, 1, 1, 0, 8'h55, 8'hC3, 8'd1, 8'd3, 2'b01);
    tbl[14] = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h55, 8'hC3, 8'd1, 8'd3, 2'b01);
    tbl[15] = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h55, 8'hC3, 8'd1, 8'd3, 2'b01);
    tbl[16] = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h55, 8'hC3, 8'd1, 8'd3, 2'b01);
    tbl[17] = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h55, 8'hC3, 8'd1, 8'd3, 2'b00);
    tbl[18] = mk(0, 1, 8'h77, 0, 0, 1, 1, 0, 8'h77, 8'hC3, 8'd2, 8'd3, 2'b01);
    // A word after two idle cycles restarts the idle count
    tbl[19] = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h77, 8'hC3, 8'd2, 8'd3, 2'b01);
    tbl[20] = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h77, 8'hC3, 8'd2, 8'd3, 2'b01);
    tbl[21] = mk(0, 1, 8'h88, 0, 1, 1, 1, 0, 8'h88, 8'hC3, 8'd3, 8'd3, 2'b01);
    tbl[22] = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h88, 8'hC3, 8'd3, 8'd3, 2'b01);
    tbl[23] = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h88, 8'hC3, 8'd3, 8'd3, 2'b01);
    tbl[24] = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h88, 8'hC3, 8'd3, 8'd3, 2'b01);
    tbl[25] = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h88, 8'hC3, 8'd3, 8'd3, 2'b00);

    reset = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    almost_full0 = 1'b0; almost_full1 = 1'b0;

    for (int i = 0; i < NV; i++) begin
      reset        = tbl[i].rst;
      valid_in     = tbl[i].vld;
      data_in      = tbl[i].din;
      almost_full0 = tbl[i].af0;
      almost_full1 = tbl[i].af1;
      #1;
      chk("ready_out", i, 32'(ready_out), 32'(tbl[i].rdy));
      @(posedge clk_4f);
      #1;
      chk("validout0", i, 32'(validout0), 32'(tbl[i].v0));
      chk("validout1", i, 32'(validout1), 32'(tbl[i].v1));
      chk("dataout0",  i, 32'(dataout0),  32'(tbl[i].d0));
      chk("dataout1",  i, 32'(dataout1),  32'(tbl[i].d1));
      chk("cnt0",      i, 32'(cnt0),      32'(tbl[i].c0));
      chk("cnt1",      i, 32'(cnt1),      32'(tbl[i].c1));
      chk("state",     i, 32'(state),     32'(tbl[i].st));
    end

    // Counter wrap: 256 words forced onto lane 0 from a clean reset
    reset = 1'b1; valid_in = 1'b0;
    @(posedge clk_4f);
    #1;
    reset = 1'b0;
    almost_full0 = 1'b0;
    almost_full1 = 1'b1;
    spurious = 0;
    for (int i = 0; i < 256; i++) begin
      valid_in = 1'b1;
      data_in  = 8'(i);
      @(posedge clk_4f);
      #1;
      if (validout1 !== 1'b0 || validout0 !== 1'b1) spurious++;
      if (i == 254) chk("wrap_cnt0_ff", i, 32'(cnt0), 32'h0000_00FF);
    end
    valid_in = 1'b0;
    chk("wrap_bad_valids", 0, 32'(spurious), 32'd0);
    chk("wrap_cnt0",       0, 32'(cnt0),     32'h0);
    chk("wrap_cnt1",       0, 32'(cnt1),     32'h0);
    chk("wrap_dataout0",   0, 32'(dataout0), 32'hFF);
    chk("wrap_state",      0, 32'(state),    32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_lane_scheduler.md
Name: demux_lane_scheduler

Overview:
- Sequences the 8-bit 1-to-2 demux stage that feeds the two downstream lane FIFOs, running on clk_4f.
- Each accepted upstream word is steered to lane 0 or lane 1 in round-robin order.
- A lane whose FIFO reports almost_full is skipped. When both lanes are almost full, the upstream source is back-pressured.
- Outputs are registered. The block also keeps per-lane word counters and a state/status output for debug.

Parameters:
- DATA_W, 8, width of data word.
- CNT_W, 8, width of per-lane accepted-word counters (wrap-around).
- IDLE_TO, 4, number of consecutive idle cycles in ACTIVE that return the FSM to IDLE and re-align the pointer to lane 0.

Ports:
- clk_4f  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  upstream word valid.
- data_in  in  DATA_W  upstream word.
- almost_full0  in  1  lane-0 FIFO almost full.
- almost_full1  in  1  lane-1 FIFO almost full.
- ready_out  out  1  upstream may present a word (combinational).
- validout0  out  1  lane-0 word valid (registered).
- validout1  out  1  lane-1 word valid (registered).
- dataout0  out  DATA_W  lane-0 word (registered).
- dataout1  out  DATA_W  lane-1 word (registered).
- cnt0  out  CNT_W  words routed to lane 0 since reset.
- cnt1  out  CNT_W  words routed to lane 1 since reset.
- state  out  2  FSM state: 00 IDLE, 01 ACTIVE, 10 STALL.

Behaviour:
- Reset (reset=1 at a clk_4f edge): state=IDLE, pointer=0, validout0/1=0, dataout0/1=0, cnt0/1=0, idle counter=0. Reset mid-transfer drops any in-flight output word at that edge.
- ready_out = !(almost_full0 & almost_full1) in every state; it is still driven during reset.
- Accept = valid_in & ready_out.
- Lane choice on accept:
  - Target the pointer lane if its almost_full is 0; otherwise target the other lane.
  - After routing, pointer = complement of the routed lane.
- Output register:
  - On accept, at the next edge, validoutX=1 and dataoutX=data_in for the routed lane X only. The other lane's valid is 0 and its data holds its last value.
  - With no accept, both valids are 0 and data holds. Latency is 1 cycle; throughput is 1 word/cycle.
- Counters: cntX increments on each word routed to lane X and wraps from 2^CNT_W-1 to 0.
- FSM:
  - IDLE: pointer is forced to 0. On accept, go to ACTIVE. On valid_in while both lanes are almost full, go to STALL.
  - ACTIVE:
    - valid_in & !ready_out -> STALL.
    - valid_in=0 -> increment idle counter. When it reaches IDLE_TO, go to IDLE and set pointer=0.
    - Any valid_in resets the idle counter.
  - STALL: no words accepted. When ready_out=1, go to ACTIVE (same edge evaluation). The pointer is unchanged through STALL.
- Simultaneous events: one lane almost full with valid_in -> the word goes to the free lane. almost_full changing in the same cycle as valid_in -> the current-cycle values decide.
- The block never drops an accepted word. A word presented with ready_out=0 must be held by the upstream source.

Decomposition:
- Shared package:
  - state encodings ST_IDLE=2'b00, ST_ACTIVE=2'b01, ST_STALL=2'b10;
  - lane index constants LANE0/LANE1;
  - default DATA_W/CNT_W.
- One sub-module, lane_out_reg: DATA_W output register with valid, load enable and synchronous reset. It is instantiated twice, once per lane.
- FSM, pointer and counters live in the top level.

Test Plan:
- Reset check: assert reset for 2 cycles mid-stream (valid_in=1, data 0x5A). Required: next cycle validout0/1=0, dataout0/1=0x00, cnt0/1=0, state=00.
- Round-robin: afs=0; send 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Required: lane0 gets 0x11 then 0x33, lane1 gets 0x22 then 0x44, each 1 cycle later; cnt0=cnt1=2.
- Skip: almost_full0=1, pointer at 0; send 0xA1, 0xA2. Required: both words go to lane 1; cnt1 +2, cnt0 unchanged.
- Stall: both afs=1 with valid_in=1 and 0xC3. Required: ready_out=0, no validouts, state=10. Release almost_full1 -> 0xC3 goes to lane1 one cycle after acceptance; state=01.
- Idle realign: send one word to lane 0 (pointer becomes 1), then 4 idle cycles. Required: state=00. Next word 0x77 goes to lane 0.
- Counter wrap: route 256 words to lane 0 (almost_full1=1). Required: cnt0 returns to 0x00, no spurious validout1.
